// File: rtl/lcd_byte_writer_pkg.sv
// Shared types and constants for the character-LCD byte writer.
// No logic: state encodings, command codes, default gap lengths.
// No handshake: pure declarations.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HI_PULSE = 3'd1,
    ST_NIB_GAP  = 3'd2,
    ST_LO_PULSE = 3'd3,
    ST_BYTE_GAP = 3'd4
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Cycle counts at 50 MHz
  localparam int unsigned DEF_NIBBLE_GAP     = 50;     // 1 us
  localparam int unsigned DEF_BYTE_GAP       = 2000;   // 40 us
  localparam int unsigned DEF_LONG_GAP       = 82000;  // 1.64 ms
  localparam int unsigned DEF_ENABLE_TIMEOUT = 64;

  localparam int TMR_W = 32;

  // Clear (0x01) and Home (0x02/0x03, bit 0 is don't-care) need the long execution time
  function automatic logic is_long_cmd(input logic [7:0] b, input logic rs);
    return !rs && ((b == LCD_CMD_CLEAR) || (b[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Bundle of the sequencer-side handshake and the LCD/enable-stage pins.
// No latency: wiring only.
// oReady gates iWrite; iEnableDone is a level held by the enable stage.
interface lcd_byte_writer_if;
  logic [7:0] iData;
  logic       iRS;
  logic       iWrite;
  logic       oReady;
  logic       oDone;
  logic       oError;
  logic [3:0] oLCD_Data;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic       oEnableReset;
  logic       iEnableDone;

  // Sequencer plus enable stage (drives all inputs of the writer)
  modport master (
    output iData, iRS, iWrite, iEnableDone,
    input  oReady, oDone, oError, oLCD_Data, oLCD_RS, oLCD_RW, oEnableReset
  );

  // The byte writer itself
  modport slave (
    input  iData, iRS, iWrite, iEnableDone,
    output oReady, oDone, oError, oLCD_Data, oLCD_RS, oLCD_RW, oEnableReset
  );
endinterface

// File: rtl/lcd_byte_writer_gap_timer.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
// Load takes effect on the next edge; loading N-1 gives an N-cycle interval.
// No backpressure: load always wins over counting.
module lcd_gap_timer
  import lcd_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_count;

  // Count down to zero and park there until reloaded
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// Splits a byte into two nibble writes for a 4-bit HD44780 bus, pacing E pulses and gaps.
// Latency: 2*enable-pulse + NIBBLE_GAP + BYTE_GAP (+LONG_GAP for Clear/Home with LCD_LONG_CMD_EN) + 1 cycles.
// oReady low while busy; iWrite then is dropped, never queued. Macro: LCD_LONG_CMD_EN.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned NIBBLE_GAP     = DEF_NIBBLE_GAP,
  parameter int unsigned BYTE_GAP       = DEF_BYTE_GAP,
  parameter int unsigned LONG_GAP       = DEF_LONG_GAP,
  parameter int unsigned ENABLE_TIMEOUT = DEF_ENABLE_TIMEOUT
) (
  input logic          Clock,
  input logic          Reset,
  lcd_byte_writer_if.slave bus
);

  localparam logic [TMR_W-1:0] C_TIMEOUT = 32'(ENABLE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] C_NIB     = 32'(NIBBLE_GAP - 1);
  localparam logic [TMR_W-1:0] C_BYTE    = 32'(BYTE_GAP - 1);
  localparam logic [TMR_W-1:0] C_LONG    = 32'(LONG_GAP - 1);

  lcd_state_e r_state, w_state_nxt;
  logic [7:0] r_byte, w_byte_nxt;
  logic       r_rs, w_rs_latch_nxt;
  logic       r_ready, w_ready_nxt;
  logic       r_done, w_done_nxt;
  logic       r_error, w_error_nxt;
  logic [3:0] r_lcd_data, w_lcd_data_nxt;
  logic       r_lcd_rs, w_lcd_rs_nxt;
  logic       r_en_rst, w_en_rst_nxt;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_expired;
  logic             w_long_cmd;
  logic [TMR_W-1:0] w_post_gap;

  lcd_gap_timer u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_expired)
  );

`ifdef LCD_LONG_CMD_EN
  assign w_long_cmd = is_long_cmd(r_byte, r_rs);
`else
  assign w_long_cmd = 1'b0;
`endif
  assign w_post_gap = w_long_cmd ? C_LONG : C_BYTE;

  // State and registered outputs; reset abandons any byte in flight
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_byte     <= '0;
      r_rs       <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_lcd_data <= '0;
      r_lcd_rs   <= 1'b0;
      r_en_rst   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_byte     <= w_byte_nxt;
      r_rs       <= w_rs_latch_nxt;
      r_ready    <= w_ready_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_lcd_data <= w_lcd_data_nxt;
      r_lcd_rs   <= w_lcd_rs_nxt;
      r_en_rst   <= w_en_rst_nxt;
    end
  end

  // Next state and next output values; data/RS only move on the edge where E-reset falls
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_nxt     = r_byte;
    w_rs_latch_nxt = r_rs;
    w_ready_nxt    = r_ready;
    w_done_nxt     = 1'b0;
    w_error_nxt    = r_error;
    w_lcd_data_nxt = r_lcd_data;
    w_lcd_rs_nxt   = r_lcd_rs;
    w_en_rst_nxt   = r_en_rst;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;

    case (r_state)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        if (r_ready && bus.iWrite) begin
          w_byte_nxt     = bus.iData;
          w_rs_latch_nxt = bus.iRS;
          w_error_nxt    = 1'b0;
          w_ready_nxt    = 1'b0;
          w_lcd_data_nxt = bus.iData[7:4];
          w_lcd_rs_nxt   = bus.iRS;
          w_en_rst_nxt   = 1'b0;
          w_tmr_load     = 1'b1;
          w_tmr_val      = C_TIMEOUT;
          w_state_nxt    = ST_HI_PULSE;
        end
      end

      ST_HI_PULSE: begin
        w_lcd_data_nxt = r_byte[7:4];
        if (bus.iEnableDone) begin
          w_en_rst_nxt = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_val    = C_NIB;
          w_state_nxt  = ST_NIB_GAP;
        end else if (w_tmr_expired) begin
          w_error_nxt  = 1'b1;
          w_en_rst_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end

      ST_NIB_GAP: begin
        if (w_tmr_expired) begin
          w_lcd_data_nxt = r_byte[3:0];
          w_lcd_rs_nxt   = r_rs;
          w_en_rst_nxt   = 1'b0;
          w_tmr_load     = 1'b1;
          w_tmr_val      = C_TIMEOUT;
          w_state_nxt    = ST_LO_PULSE;
        end
      end

      ST_LO_PULSE: begin
        w_lcd_data_nxt = r_byte[3:0];
        if (bus.iEnableDone) begin
          w_en_rst_nxt = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_val    = w_post_gap;
          w_state_nxt  = ST_BYTE_GAP;
        end else if (w_tmr_expired) begin
          w_error_nxt  = 1'b1;
          w_en_rst_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end

      ST_BYTE_GAP: begin
        if (w_tmr_expired) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_en_rst_nxt = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  assign bus.oReady       = r_ready;
  assign bus.oDone        = r_done;
  assign bus.oError       = r_error;
  assign bus.oLCD_Data    = r_lcd_data;
  assign bus.oLCD_RS      = r_lcd_rs;
  assign bus.oLCD_RW      = 1'b0;
  assign bus.oEnableReset = r_en_rst;

endmodule

// File: doc/lcd_byte_writer.md
Name: lcd_byte_writer

Overview:
- Upstream driver for the LCD enable-pulse stage on the Spartan-3E character LCD, using the 4-bit interface.
- Accepts one byte plus an RS flag from the command/text sequencer and splits it into high and low nibbles.
- Presents each nibble on the LCD data and RS lines, then releases the enable stage's reset so it produces one E pulse, and waits for its done flag.
- Enforces the HD44780 inter-nibble gap and post-byte execution gap, then signals completion.

Parameters:
- NIBBLE_GAP, 50: idle cycles between low-nibble start and prior pulse done (1 us at 50 MHz).
- BYTE_GAP, 2000: idle cycles after the low-nibble pulse before the next byte is accepted (40 us).
- LONG_GAP, 82000: post-byte gap for Clear/Home commands (1.64 ms); used only with LCD_LONG_CMD_EN.
- ENABLE_TIMEOUT, 64: maximum cycles to wait for iEnableDone before flagging an error.

Ports:
- Clock, input, 1: system clock, 50 MHz.
- Reset, input, 1: asynchronous, active-low reset.
- iData, input, 8: byte to write.
- iRS, input, 1: 0 = command, 1 = data.
- iWrite, input, 1: write request; accepted only while oReady=1.
- oReady, output, 1: idle; can accept iWrite.
- oDone, output, 1: one-cycle pulse when a byte, including its post-byte gap, is complete.
- oError, output, 1: sticky enable-timeout flag.
- oLCD_Data, output, 4: LCD DB[7:4].
- oLCD_RS, output, 1: LCD RS.
- oLCD_RW, output, 1: LCD R/W; constant 0 (write-only).
- oEnableReset, output, 1: active-high reset to the enable-pulse stage; 0 = run one pulse sequence.
- iEnableDone, input, 1: done flag from the enable stage; level, held until that stage is reset.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE.
  - oReady=1, oDone=0, oError=0.
  - oLCD_Data=0, oLCD_RS=0, oLCD_RW=0.
  - oEnableReset=1.
  - Counter = 0; latched byte/RS = 0.
- A reset mid-operation abandons the byte immediately. No oDone is issued, and oEnableReset returns to 1 at once.
- All outputs are registered.
- States:
  - IDLE: oReady=1. When iWrite=1, latch iData/iRS, clear oError, set oReady=0, go to HI_PULSE. iWrite while oReady=0 is ignored and not queued.
  - HI_PULSE: oLCD_Data=byte[7:4], oLCD_RS=latched RS, oEnableReset=0, counter counts up.
    - iEnableDone=1: oEnableReset=1, counter=0, go to NIB_GAP.
    - Counter reaching ENABLE_TIMEOUT-1 without iEnableDone: set oError, oEnableReset=1, go to IDLE; no oDone.
  - NIB_GAP: data and RS held. Exactly NIBBLE_GAP cycles here (exit when counter==NIBBLE_GAP-1), then go to LO_PULSE.
  - LO_PULSE: as HI_PULSE, with oLCD_Data=byte[3:0]. Done → BYTE_GAP; timeout → IDLE with oError.
  - BYTE_GAP: exactly BYTE_GAP cycles (LONG_GAP if the long-command condition holds). On exit, oDone=1 for one cycle coincident with the return to IDLE; oReady=1 on the next cycle.
- oLCD_Data/oLCD_RS change only in the cycle oEnableReset falls. They are stable for the whole pulse and gap; the enable stage's 40 ns low phase provides address setup.
- Counter is 32-bit and cleared on every state change; it never wraps within legal parameter values.
- Minimum latency, iWrite accepted to oDone: 2×(enable-stage duration) + NIBBLE_GAP + BYTE_GAP + 1 cycles.

Optional Feature:
- Macro: LCD_LONG_CMD_EN.
- Defined: when latched RS=0 and byte is 8'h01 or byte[7:1]=7'b0000001 (Clear/Home), BYTE_GAP state lasts LONG_GAP cycles.
- Undefined: always BYTE_GAP; the LONG_GAP parameter is unused.

Decomposition:
- Shared package/header `lcd_pkg`:
  - State encodings (IDLE=0, HI_PULSE=1, NIB_GAP=2, LO_PULSE=3, BYTE_GAP=4).
  - Command constants LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02.
  - Default gap cycle counts.
- One sub-module is natural: `lcd_gap_timer`, a loadable down-counter with an expiry flag, shared by the gap and timeout logic.
- The enable-pulse stage stays external.

Test Plan:
- Reset held low, then released → oReady=1, oEnableReset=1, oLCD_Data=0, oLCD_RW=0. No change while iWrite=0.
- iWrite with iData=8'h48, iRS=1; enable model returns done 15 cycles after release →
  - oLCD_Data=4'h4 then 4'h8, oLCD_RS=1.
  - Exactly 50 cycles between the first oEnableReset rise and its second fall.
  - oDone after 2000 BYTE_GAP cycles; oError=0.
- iWrite pulsed again during NIB_GAP → ignored; exactly one oDone, and second-byte data never appears.
- Enable model never asserts done → oError=1 after 64 cycles in HI_PULSE, return to IDLE, no oDone. Next valid write clears oError.
- iData=8'h01, iRS=0:
  - LCD_LONG_CMD_EN defined → BYTE_GAP=82000 cycles.
  - Undefined → 2000 cycles.
- Reset asserted in LO_PULSE → outputs return to reset values asynchronously within the same cycle; no oDone; next write proceeds normally.
